// File: rtl/affine_loop_ctrl.sv
// Affine-schedule loop-nest controller driving one unified-buffer port (wen/ren + ctrl_vars).
// Optional stall input is compiled in when LOOP_CTRL_STALL_EN is defined.
module affine_loop_ctrl #(
    parameter int NDIM = 3,
    parameter int IW   = 16,
    parameter int TW   = 32
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_flush,
    input  logic [NDIM-1:0][IW-1:0] i_cfg_extent,
    input  logic [NDIM-1:0][TW-1:0] i_cfg_stride,
    input  logic [TW-1:0]           i_cfg_offset,
`ifdef LOOP_CTRL_STALL_EN
    input  logic                    i_stall,
`endif
    output logic                    o_valid,
    output logic [NDIM-1:0][IW-1:0] o_ctrl_vars,
    output logic                    o_done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [TW-1:0]           r_cnt;
    logic [TW-1:0]           r_next_t;
    logic [NDIM-1:0][IW-1:0] r_idx;
    logic [NDIM-1:0][IW-1:0] w_idx_adv;
    logic [TW-1:0]           w_next_t;
    logic                    w_last;
    logic                    w_zero_ext;
    logic                    w_stall;
    logic                    w_valid;
    logic                    w_done;
    logic                    w_carry;

`ifdef LOOP_CTRL_STALL_EN
    assign w_stall = i_stall;
`else
    assign w_stall = 1'b0;
`endif

    // Last-point and empty-nest detection from the current indices and extents.
    always_comb begin
        w_last     = 1'b1;
        w_zero_ext = 1'b0;
        for (int d = 0; d < NDIM; d++) begin
            w_last     = w_last & (r_idx[d] == (i_cfg_extent[d] - IW'(1)));
            w_zero_ext = w_zero_ext | (i_cfg_extent[d] == IW'(0));
        end
    end

    // Odometer advance: innermost dimension steps, wrapping dimensions carry outward.
    always_comb begin
        w_idx_adv = r_idx;
        w_carry   = 1'b1;
        for (int d = NDIM - 1; d >= 0; d--) begin
            if (!w_carry) begin
                w_idx_adv[d] = r_idx[d];
            end else if (r_idx[d] == (i_cfg_extent[d] - IW'(1))) begin
                w_idx_adv[d] = IW'(0);
            end else begin
                w_idx_adv[d] = r_idx[d] + IW'(1);
                w_carry      = 1'b0;
            end
        end
    end

    // Schedule time of the advanced point, modulo 2^TW.
    always_comb begin
        w_next_t = i_cfg_offset;
        for (int d = 0; d < NDIM; d++) begin
            w_next_t = w_next_t + (i_cfg_stride[d] * TW'(w_idx_adv[d]));
        end
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; flush restarts from any state.
    always_comb begin
        w_state_nxt = r_state;
        if (i_flush) begin
            w_state_nxt = w_zero_ext ? S_DONE : S_RUN;
        end else begin
            case (r_state)
                S_IDLE:  w_state_nxt = S_IDLE;
                S_RUN:   w_state_nxt = (w_valid && w_last) ? S_DONE : S_RUN;
                S_DONE:  w_state_nxt = S_DONE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Output decode from registered state, counter and target time.
    always_comb begin
        w_valid = 1'b0;
        w_done  = 1'b0;
        case (r_state)
            S_RUN: begin
                w_valid = (r_cnt == r_next_t) && !w_stall;
                w_done  = 1'b0;
            end
            S_DONE: begin
                w_valid = 1'b0;
                w_done  = 1'b1;
            end
            default: begin
                w_valid = 1'b0;
                w_done  = 1'b0;
            end
        endcase
    end

    // Counter, indices and target time; the final point keeps its indices for DONE.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt    <= '0;
            r_next_t <= '0;
            r_idx    <= '0;
        end else if (i_flush) begin
            r_cnt    <= '0;
            r_next_t <= i_cfg_offset;
            r_idx    <= '0;
        end else if ((r_state == S_RUN) && !w_stall) begin
            r_cnt <= r_cnt + TW'(1);
            if (w_valid && !w_last) begin
                r_idx    <= w_idx_adv;
                r_next_t <= w_next_t;
            end else begin
                r_idx    <= r_idx;
                r_next_t <= r_next_t;
            end
        end else begin
            r_cnt    <= r_cnt;
            r_next_t <= r_next_t;
            r_idx    <= r_idx;
        end
    end

    assign o_valid     = w_valid;
    assign o_done      = w_done;
    assign o_ctrl_vars = r_idx;

endmodule

// File: tb/tb_affine_loop_ctrl.sv
// Directed bench for affine_loop_ctrl: table of schedules plus flush/reset/stall sequences.
module tb_affine_loop_ctrl;

    logic             clk;
    logic             rst;
    logic             flush;
    logic [2:0][15:0] ext;
    logic [2:0][31:0] str;
    logic [31:0]      off;
    logic             stall;
    logic             valid;
    logic [2:0][15:0] ctrl;
    logic             done;

    int n_chk;
    int n_err;

    affine_loop_ctrl #(.NDIM(3), .IW(16), .TW(32)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_flush      (flush),
        .i_cfg_extent (ext),
        .i_cfg_stride (str),
        .i_cfg_offset (off),
`ifdef LOOP_CTRL_STALL_EN
        .i_stall      (stall),
`endif
        .o_valid      (valid),
        .o_ctrl_vars  (ctrl),
        .o_done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete, errors so far %0d", n_err);
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [2:0][15:0] ext;
        logic [2:0][31:0] str;
        logic [31:0]      off;
        int               n_fire;
        int               first_r;
        int               last_r;
        int               done_r;
        logic [47:0]      last_idx;
        bit               illegal;
    } vec_t;

    vec_t vecs[6];

    function automatic logic [47:0] ix(input int a, input int b, input int c);
        ix = {16'(c), 16'(b), 16'(a)};
    endfunction

    function automatic logic [31:0] sched(input logic [2:0][15:0] i, input logic [2:0][31:0] s,
                                          input logic [31:0] o);
        logic [31:0] t;
        t = o;
        for (int d = 0; d < 3; d++) t = t + s[d] * 32'(i[d]);
        return t;
    endfunction

    function automatic bit is_last(input logic [2:0][15:0] i, input logic [2:0][15:0] e);
        bit l;
        l = 1'b1;
        for (int d = 0; d < 3; d++) if (i[d] != e[d] - 16'd1) l = 1'b0;
        return l;
    endfunction

    function automatic logic [2:0][15:0] adv(input logic [2:0][15:0] i, input logic [2:0][15:0] e);
        logic [2:0][15:0] n;
        n = i;
        for (int d = 2; d >= 0; d--) begin
            if (n[d] == e[d] - 16'd1) begin
                n[d] = 16'd0;
            end else begin
                n[d] = n[d] + 16'd1;
                break;
            end
        end
        return n;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_vec(input int v, input int e0, input int e1, input int e2,
                           input int s0, input int s1, input int s2, input int o,
                           input int nf, input int fr, input int lr, input int dr,
                           input logic [47:0] li, input bit ill);
        vecs[v].ext[0] = 16'(e0); vecs[v].ext[1] = 16'(e1); vecs[v].ext[2] = 16'(e2);
        vecs[v].str[0] = 32'(s0); vecs[v].str[1] = 32'(s1); vecs[v].str[2] = 32'(s2);
        vecs[v].off = 32'(o);
        vecs[v].n_fire = nf; vecs[v].first_r = fr; vecs[v].last_r = lr; vecs[v].done_r = dr;
        vecs[v].last_idx = li; vecs[v].illegal = ill;
    endtask

    // Flush sampled at the next rising edge E0; returns just after E0 (cycle r=1 follows).
    task automatic do_flush();
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    task automatic run_vec(input int v);
        int r, nf, fr, lr, dr, seq_bad, budget;
        bit ill, all_fired;
        logic [2:0][15:0] ei;
        logic [31:0] t, tn;
        ext = vecs[v].ext; str = vecs[v].str; off = vecs[v].off;
        nf = 0; fr = -1; lr = -1; dr = -1; seq_bad = 0; ill = 1'b0;
        budget = (vecs[v].done_r > 0) ? vecs[v].done_r + 5 : 60;
        ei = '0;
        t = sched(ei, vecs[v].str, vecs[v].off);
        all_fired = (ext[0] == 16'd0) || (ext[1] == 16'd0) || (ext[2] == 16'd0);
        do_flush();
        for (r = 1; r <= budget; r++) begin
            @(negedge clk);
            if (valid) begin
                nf++;
                if (fr < 0) fr = r;
                lr = r;
                if (all_fired || ctrl != ei || 32'(r - 1) != t) begin
                    seq_bad++;
                end else if (is_last(ei, vecs[v].ext)) begin
                    all_fired = 1'b1;
                end else begin
                    ei = adv(ei, vecs[v].ext);
                    tn = sched(ei, vecs[v].str, vecs[v].off);
                    if (tn <= t) ill = 1'b1;
                    t = tn;
                end
            end
            if (done) begin
                dr = r;
                chk($sformatf("v%0d_valid_in_done", v), longint'(valid), 0);
                break;
            end
        end
        chk($sformatf("v%0d_nfire", v), nf, vecs[v].n_fire);
        chk($sformatf("v%0d_first", v), fr, vecs[v].first_r);
        chk($sformatf("v%0d_last", v), lr, vecs[v].last_r);
        chk($sformatf("v%0d_done", v), dr, vecs[v].done_r);
        chk($sformatf("v%0d_final_idx", v), longint'(ctrl), longint'(vecs[v].last_idx));
        chk($sformatf("v%0d_seq", v), seq_bad, 0);
        chk($sformatf("v%0d_cfg_err", v), longint'(ill), longint'(vecs[v].illegal));
    endtask

    initial begin
        int cnt_v, cnt_d, fr, nth;
        logic [47:0] c10;
        n_chk = 0; n_err = 0;
        rst = 1'b0; flush = 1'b0; stall = 1'b0;
        ext = '0; str = '0; off = '0;

        set_vec(0, 1, 62, 62, 0, 62, 1, 5, 3844, 6, 3849, 3850, ix(0, 61, 61), 1'b0);
        set_vec(1, 1, 4, 4, 0, 8, 2, 0, 16, 1, 31, 32, ix(0, 3, 3), 1'b0);
        set_vec(2, 1, 0, 5, 0, 1, 1, 3, 0, -1, -1, 1, ix(0, 0, 0), 1'b0);
        set_vec(3, 2, 3, 2, 100, 20, 3, 7, 12, 8, 151, 152, ix(1, 2, 1), 1'b0);
        set_vec(4, 1, 1, 1, 5, 5, 5, 3, 1, 4, 4, 5, ix(0, 0, 0), 1'b0);
        set_vec(5, 1, 1, 3, 0, 0, 0, 2, 1, 3, 3, -1, ix(0, 0, 1), 1'b1);

        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_valid", longint'(valid), 0);
        chk("rst_done", longint'(done), 0);
        chk("rst_ctrl", longint'(ctrl), 0);
        ext[0] = 16'd1; ext[1] = 16'd1; ext[2] = 16'd4; str = '0; off = '0;
        cnt_v = 0;
        repeat (6) begin
            @(negedge clk);
            if (valid || done) cnt_v++;
        end
        chk("idle_no_activity", cnt_v, 0);

        for (int v = 0; v < 6; v++) run_vec(v);

        // Flush at the 10th firing of a one-per-cycle schedule.
        ext[0] = 16'd1; ext[1] = 16'd4; ext[2] = 16'd4;
        str[0] = 32'd0; str[1] = 32'd4; str[2] = 32'd1; off = 32'd3;
        do_flush();
        nth = 0; c10 = '0;
        for (int r = 1; r <= 100; r++) begin
            @(negedge clk);
            if (valid) nth++;
            if (nth == 10) begin
                c10 = ctrl;
                break;
            end
        end
        chk("mf_reach10", nth, 10);
        chk("mf_idx10", longint'(c10), longint'(ix(0, 2, 1)));
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        cnt_v = 0;
        for (int r = 1; r <= 4; r++) begin
            @(negedge clk);
            if (r == 1) chk("mf_idx_cleared", longint'(ctrl), 0);
            if (r < 4 && valid) cnt_v++;
            if (r == 4) begin
                chk("mf_refire_valid", longint'(valid), 1);
                chk("mf_refire_idx", longint'(ctrl), 0);
            end
        end
        chk("mf_no_stale", cnt_v, 0);

        // Asynchronous reset in the middle of a run.
        do_flush();
        repeat (8) @(negedge clk);
        chk("mr_pre_idx", longint'(ctrl), longint'(ix(0, 1, 0)));
        rst = 1'b1;
        #1;
        chk("mr_valid", longint'(valid), 0);
        chk("mr_done", longint'(done), 0);
        chk("mr_ctrl", longint'(ctrl), 0);
        @(negedge clk);
        rst = 1'b0;
        cnt_v = 0; cnt_d = 0;
        repeat (20) begin
            @(negedge clk);
            if (valid) cnt_v++;
            if (done) cnt_d++;
        end
        chk("mr_idle_valid", cnt_v, 0);
        chk("mr_idle_done", cnt_d, 0);
        do_flush();
        fr = -1;
        for (int r = 1; r <= 10; r++) begin
            @(negedge clk);
            if (valid && fr < 0) fr = r;
        end
        chk("mr_restart_first", fr, 4);

`ifdef LOOP_CTRL_STALL_EN
        // Stall held for three cycles at the 5th firing.
        ext[0] = 16'd1; ext[1] = 16'd1; ext[2] = 16'd8;
        str[0] = 32'd0; str[1] = 32'd0; str[2] = 32'd1; off = 32'd2;
        do_flush();
        begin
            int nf, r5, dr, vs;
            logic [47:0] c5;
            nf = 0; r5 = -1; dr = -1; vs = 0; c5 = '0;
            for (int r = 1; r <= 30; r++) begin
                stall = (r >= 7 && r <= 9);
                @(negedge clk);
                if (r >= 7 && r <= 9 && valid) vs++;
                if (valid) begin
                    nf++;
                    if (nf == 5) begin
                        r5 = r;
                        c5 = ctrl;
                    end
                end
                if (done && dr < 0) dr = r;
                @(posedge clk);
                #1;
            end
            stall = 1'b0;
            chk("st_valid_low", vs, 0);
            chk("st_fire5_cycle", r5, 10);
            chk("st_fire5_idx", longint'(c5), longint'(ix(0, 0, 4)));
            chk("st_nfire", nf, 8);
            chk("st_done", dr, 14);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
